gf8_inv: RTL
============

GF8_INV -- requirements
Module: gf8_inv

Interface
REQ-001 Parameters: none; all widths fixed at 8 bits (GF(2^8), reduction polynomial x^8+x^4+x^3+x+1).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  operand presented on in_a.
REQ-005 in_ready  output  1  block can accept an operand this cycle.
REQ-006 in_a  input  8  field element to invert.
REQ-007 out_valid  output  1  out_inv holds a valid result.
REQ-008 out_ready  input  1  consumer accepts the result this cycle.
REQ-009 out_inv  output  8  multiplicative inverse of the accepted operand.

Function
REQ-010 The block SHALL compute out_inv = in_a^254 in GF(2^8); by this definition the inverse of 0x00 SHALL be 0x00.
REQ-011 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-012 in_ready SHALL be high only in IDLE, and out_valid SHALL be high only in DONE.
REQ-013 Accept: in IDLE with in_valid=1, the edge SHALL load sq<=in_a, res<=0x01 and cnt<=0, then move to BUSY.
REQ-014 In IDLE with in_valid=0, the FSM SHALL hold and in_a SHALL be ignored.
REQ-015 Each BUSY edge SHALL compute sq'=sq*sq, then res<=res*sq', sq<=sq' and cnt<=cnt+1, as one combinational chain of two field multiplies per cycle.
REQ-016 After the 7th BUSY edge (cnt==6 at that edge) the FSM SHALL enter DONE; out_valid is therefore first high 7 cycles after the accept edge.
REQ-017 In DONE, out_inv SHALL equal res and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-018 In DONE with out_ready=1, the edge SHALL return the FSM to IDLE; the next operand is accepted no earlier than the following edge, for a throughput of one result per 9 cycles.
REQ-019 in_valid during BUSY or DONE SHALL have no effect; the producer holds its operand until in_ready.
REQ-020 out_ready while not in DONE SHALL have no effect.
REQ-021 cnt SHALL be 3 bits and SHALL never exceed 6.
REQ-022 No illegal FSM encoding SHALL be reachable; any unused encoding SHALL decode to IDLE.
REQ-023 Outputs SHALL depend only on registered state, with no combinational path from in_valid or out_ready to any output.

Reset
REQ-024 Asserting rst SHALL immediately force state=IDLE, sq=0x00, res=0x00 and cnt=0, giving in_ready=1, out_valid=0 and out_inv=0x00.
REQ-025 rst asserted during BUSY or DONE SHALL discard the operation in progress with no partial result presented.
REQ-026 On the first edge after rst deasserts, the block SHALL accept a valid operand.

Structure
REQ-027 The shared package aes_pkg SHALL hold: reduction constant 8'h1B, GF_ONE 8'h01, the iteration count 7 and the FSM state enum.
REQ-028 Both multiplies SHALL be instances of the codebase's combinational GF(2^8) multiplier gal8_mul, one as the squarer (both inputs sq) and one as the accumulator; this module SHALL contain no other field arithmetic.

Verification
REQ-029 Known values: in_a=0x53 -> out_inv=0xCA; 0xCA -> 0x53; 0x02 -> 0x8D; 0x01 -> 0x01; 0x00 -> 0x00; out_valid first high exactly 7 cycles after each accept.
REQ-030 Exhaustive check: all 256 operands back-to-back with out_ready=1 -> gal8_mul(in_a, out_inv)=0x01 for every nonzero in_a, and each accept exactly 9 cycles apart.
REQ-031 Backpressure: out_ready=0 for 20 cycles in DONE -> out_valid held, out_inv stable, in_ready=0; out_ready=1 -> IDLE on the next edge.
REQ-032 Ignored input: toggle in_valid and in_a every cycle during BUSY -> result still matches the originally accepted operand.
REQ-033 Reset mid-operation: rst at BUSY cnt=3, then in_a=0x02 -> no stale out_valid, output 0x8D after 7 cycles.
REQ-034 Asynchronous reset: rst pulse between clock edges while in DONE -> out_valid and out_inv clear before the next edge.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared GF(2^8) definitions for the AES-field blocks.
//   GF_POLY  : reduction constant for x^8+x^4+x^3+x+1 (the x^8 term is implicit)
//   GF_ONE   : multiplicative identity
//   GF_ITER  : square-and-multiply steps needed to form a^254
//   state_t  : control FSM states of gf8_inv
//   gf_xtime : multiply a field element by x with reduction
package aes_pkg;

    localparam logic [7:0]  GF_POLY = 8'h1B;
    localparam logic [7:0]  GF_ONE  = 8'h01;
    localparam int unsigned GF_ITER = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [7:0] gf_xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? GF_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/gal8_mul.sv
// Combinational GF(2^8) multiplier, reduction polynomial x^8+x^4+x^3+x+1.
// Ports:
//   i_a : multiplicand
//   i_b : multiplier
//   o_p : product i_a * i_b in GF(2^8)
module gal8_mul
    import aes_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_p
);

    logic [7:0] w_acc;
    logic [7:0] w_sh;

    // Shift-and-add: w_sh walks through i_a * x^i, accumulated for each set bit of i_b.
    always_comb begin
        w_acc = '0;
        w_sh  = i_a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i_b[i]) begin
                w_acc = w_acc ^ w_sh;
            end
            w_sh = gf_xtime(w_sh);
        end
        o_p = w_acc;
    end

endmodule

// File: rtl/gf8_inv.sv
// Multi-cycle GF(2^8) inverter: out_inv = in_a^254 (so 0x00 maps to 0x00).
// a^254 = a^2 * a^4 * ... * a^128, formed by seven square-then-accumulate
// steps, one per clock, followed by a valid/ready hand-off of the result.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : operand present on in_a
//   in_ready  : block idle and able to accept an operand
//   in_a      : field element to invert
//   out_valid : out_inv holds a finished result
//   out_ready : consumer takes the result this cycle
//   out_inv   : inverse of the accepted operand
module gf8_inv
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_inv
);

    localparam logic [2:0] CNT_LAST = 3'(GF_ITER - 1);

    state_t     r_state;
    logic [7:0] r_sq;
    logic [7:0] r_res;
    logic [2:0] r_cnt;
    logic       r_in_ready;
    logic       r_out_valid;

    logic [7:0] w_sq_next;
    logic [7:0] w_res_next;

    gal8_mul u_sqr (
        .i_a (r_sq),
        .i_b (r_sq),
        .o_p (w_sq_next)
    );

    gal8_mul u_acc (
        .i_a (r_res),
        .i_b (w_sq_next),
        .o_p (w_res_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sq        <= '0;
            r_res       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sq       <= in_a;
                        r_res      <= GF_ONE;
                        r_cnt      <= '0;
                        r_state    <= BUSY;
                        r_in_ready <= 1'b0;
                    end
                end
                BUSY: begin
                    r_sq  <= w_sq_next;
                    r_res <= w_res_next;
                    // The final step leaves cnt at its last value so it never passes 6.
                    if (r_cnt == CNT_LAST) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_inv   = r_res;

endmodule
